// File: rtl/seven_segment_chain_writer_pkg.sv
// Shared types and constants for the seven-segment chain writer.
// Holds the controller state encoding, the hex-to-segment table and the fixed bus constants.
package seven_segment_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Active-high segments {g,f,e,d,c,b,a}; element 15 is listed first.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [3:0] BYTEENABLE_DIGIT = 4'b0001;
  localparam logic [7:0] ADDR_CHAIN       = 8'd0;

endpackage

// File: rtl/seven_segment_chain_writer_if.sv
// Avalon-MM write-only bus between the chain writer (master) and the display chain (slave).
interface seven_segment_chain_writer_if;

  logic        avm_m0_chipselect;
  logic        avm_m0_write;
  logic [3:0]  avm_m0_byteenable;
  logic [7:0]  avm_m0_address;
  logic [31:0] avm_m0_writedata;
  logic        avm_m0_waitrequest;

  modport master (
    output avm_m0_chipselect, avm_m0_write, avm_m0_byteenable,
           avm_m0_address, avm_m0_writedata,
    input  avm_m0_waitrequest
  );

  modport slave (
    input  avm_m0_chipselect, avm_m0_write, avm_m0_byteenable,
           avm_m0_address, avm_m0_writedata,
    output avm_m0_waitrequest
  );

endinterface

// File: rtl/seven_segment_chain_writer_hex_to_seven_segment.sv
// Combinational encoder: one hex nibble to an 8-bit {dp,g,f,e,d,c,b,a} segment pattern.
module hex_to_seven_segment
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dp_i,
  input  logic       active_low_i,
  output logic [7:0] pattern_o
);

  logic [7:0] raw;

  // Blank only suppresses a..g; the decimal point stays under dp control.
  always_comb begin
    raw       = {dp_i, blank_i ? 7'd0 : SEG7_TABLE[nibble_i]};
    pattern_o = active_low_i ? ~raw : raw;
  end

endmodule

// File: rtl/seven_segment_chain_writer.sv
// Avalon-MM master that pushes one encoded segment pattern per digit down a display chain,
// most-significant digit first, with optional idle gaps between accepted writes.
module seven_segment_chain_writer
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int GAP_CYCLES = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    busy,
  output logic                    done,
  seven_segment_chain_writer_if.master avm
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]       GAP_RELOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [7:0]              gap_q;
  logic                    write_q;
  logic [3:0]              be_q;
  logic [7:0]              wdata_q;
  logic                    busy_q;
  logic                    done_q;

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   blank_q;

  logic [IDX_W-1:0]        enc_idx;
  logic [4*NUM_DIGITS-1:0] src_value;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [NUM_DIGITS-1:0]   src_blank;
  logic [7:0]              pattern;
  logic                    accept;

  assign accept = write_q & ~avm.avm_m0_waitrequest;

  // The encoder looks one step ahead so the next pattern can be registered on the same edge
  // that moves the FSM: the raw inputs on start, the next lower digit on a back-to-back accept.
  always_comb begin
    enc_idx   = idx_q;
    src_value = value_q;
    src_dp    = dp_q;
    src_blank = blank_q;
    if (state_q == ST_IDLE) begin
      enc_idx   = IDX_LAST;
      src_value = value;
      src_dp    = dp_mask;
      src_blank = blank_mask;
    end else if (state_q == ST_WRITE && idx_q != '0) begin
      enc_idx = idx_q - 1'b1;
    end
  end

  hex_to_seven_segment u_enc (
    .nibble_i     (src_value[{enc_idx, 2'b00} +: 4]),
    .blank_i      (src_blank[enc_idx]),
    .dp_i         (src_dp[enc_idx]),
    .active_low_i (ACTIVE_LOW != 0),
    .pattern_o    (pattern)
  );

  always_ff @(posedge clock) begin
    if (state_q == ST_IDLE && start) begin
      value_q <= value;
      dp_q    <= dp_mask;
      blank_q <= blank_mask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_WRITE;
            idx_q   <= IDX_LAST;
            write_q <= 1'b1;
            be_q    <= BYTEENABLE_DIGIT;
            wdata_q <= pattern;
            busy_q  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            if (idx_q == '0) begin
              state_q <= ST_DONE;
              write_q <= 1'b0;
              be_q    <= '0;
              wdata_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q - 1'b1;
              if (GAP_CYCLES == 0) begin
                wdata_q <= pattern;
              end else begin
                state_q <= ST_GAP;
                gap_q   <= GAP_RELOAD;
                write_q <= 1'b0;
                be_q    <= '0;
                wdata_q <= '0;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_q <= ST_WRITE;
            write_q <= 1'b1;
            be_q    <= BYTEENABLE_DIGIT;
            wdata_q <= pattern;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign avm.avm_m0_write      = write_q;
  assign avm.avm_m0_chipselect = write_q;
  assign avm.avm_m0_byteenable = be_q;
  assign avm.avm_m0_address    = ADDR_CHAIN;
  assign avm.avm_m0_writedata  = {24'd0, wdata_q};

endmodule

// File: tb/tb_seven_segment_chain_writer.sv
// Scoreboard bench for seven_segment_chain_writer: two instances (active-high/no gap and
// active-low/2-cycle gap), directed latency cases plus randomized updates with random stalls.
module tb_seven_segment_chain_writer;

  localparam int ND = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start_s [2];
  logic [4*ND-1:0] value_s [2];
  logic [ND-1:0]   dp_s    [2];
  logic [ND-1:0]   bl_s    [2];
  logic            busy_s  [2];
  logic            done_s  [2];
  logic            wreq    [2];
  logic            wr_s    [2];
  logic            cs_s    [2];
  logic [3:0]      be_s    [2];
  logic [7:0]      ad_s    [2];
  logic [31:0]     wd_s    [2];
  logic [7:0]      expq    [2][$];

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  function automatic logic [7:0] ref_pat(logic [3:0] n, logic dp, logic bl, bit al);
    logic [6:0] s;
    logic [7:0] p;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    p = {dp, bl ? 7'h00 : s};
    return al ? ~p : p;
  endfunction

  task automatic check(string nm, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    seven_segment_chain_writer_if bus ();

    assign bus.avm_m0_waitrequest = wreq[g];
    assign wr_s[g] = bus.avm_m0_write;
    assign cs_s[g] = bus.avm_m0_chipselect;
    assign be_s[g] = bus.avm_m0_byteenable;
    assign ad_s[g] = bus.avm_m0_address;
    assign wd_s[g] = bus.avm_m0_writedata;

    seven_segment_chain_writer #(
      .NUM_DIGITS (ND),
      .GAP_CYCLES ((g == 0) ? 0 : 2),
      .ACTIVE_LOW ((g == 0) ? 0 : 1)
    ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start_s[g]),
      .value      (value_s[g]),
      .dp_mask    (dp_s[g]),
      .blank_mask (bl_s[g]),
      .busy       (busy_s[g]),
      .done       (done_s[g]),
      .avm        (bus.master)
    );

    logic        hold_prev = 1'b0;
    logic [31:0] wd_prev   = '0;

    always @(negedge clock) begin
      if (reset) begin
        hold_prev = 1'b0;
      end else begin
        check($sformatf("bus_ctrl%0d", g), {cs_s[g], be_s[g], ad_s[g]},
              {wr_s[g], wr_s[g] ? 4'b0001 : 4'b0000, 8'h00});
        if (wr_s[g]) begin
          check($sformatf("busy_in_write%0d", g), busy_s[g], 1);
          if (hold_prev) check($sformatf("hold_stable%0d", g), wd_s[g], wd_prev);
          if (!wreq[g]) begin
            check($sformatf("sb_nonempty%0d", g), expq[g].size() != 0, 1);
            if (expq[g].size() != 0)
              check($sformatf("wdata%0d", g), wd_s[g], {24'h0, expq[g].pop_front()});
          end
        end
        if (done_s[g]) begin
          check($sformatf("done_all_written%0d", g), expq[g].size(), 0);
          check($sformatf("busy_at_done%0d", g), busy_s[g], 0);
        end
        hold_prev = wr_s[g] && wreq[g];
        wd_prev   = wd_s[g];
      end
    end
  end

  task automatic issue(int k, logic [15:0] v, logic [3:0] dp, logic [3:0] bl);
    for (int i = ND - 1; i >= 0; i--)
      expq[k].push_back(ref_pat(v[4*i +: 4], dp[i], bl[i], k == 1));
    start_s[k] = 1'b1;
    value_s[k] = v;
    dp_s[k]    = dp;
    bl_s[k]    = bl;
    @(posedge clock); #1;
    start_s[k] = 1'b0;
    value_s[k] = 16'($urandom);
    dp_s[k]    = 4'($urandom);
    bl_s[k]    = 4'($urandom);
    check("first_write_latency", wr_s[k], 1);
    check("busy_after_start", busy_s[k], 1);
  endtask

  // t counts cycles after the start edge; returns the cycle in which done is seen.
  task automatic run_until_done(int k, int budget, int st, int sl, bit rnd, bit poke,
                                output int lat, output int wcyc);
    int t;
    t    = 1;
    lat  = -1;
    wcyc = 0;
    while (t <= budget) begin
      wreq[k] = rnd ? ($urandom_range(0, 2) == 0) : (t >= st && t < st + sl);
      if (poke) begin
        start_s[k] = (t == 2);
        if (t == 2) value_s[k] = 16'hFFFF;
      end
      if (done_s[k]) begin
        lat = t;
        break;
      end
      if (wr_s[k]) wcyc++;
      @(posedge clock); #1;
      t++;
    end
    wreq[k]    = 1'b0;
    start_s[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int wc;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      value_s[k] = '0;
      dp_s[k]    = '0;
      bl_s[k]    = '0;
      wreq[k]    = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("rst_write", wr_s[k], 0);
      check("rst_busy", busy_s[k], 0);
      check("rst_done", done_s[k], 0);
      check("rst_wdata", wd_s[k], 0);
      check("rst_be", be_s[k], 0);
    end

    issue(0, 16'h1234, 4'h0, 4'h0);
    run_until_done(0, 50, 0, 0, 0, 0, lat, wc);
    check("t1_done_latency", lat, 5);
    check("t1_write_cycles", wc, 4);
    @(posedge clock); #1;

    issue(0, 16'h1234, 4'h0, 4'h0);
    run_until_done(0, 50, 2, 3, 0, 0, lat, wc);
    check("t2_done_latency", lat, 8);
    check("t2_write_cycles", wc, 7);
    @(posedge clock); #1;

    issue(1, 16'h80F0, 4'b0001, 4'b0100);
    run_until_done(1, 50, 0, 0, 0, 0, lat, wc);
    check("t3_done_latency", lat, 11);
    check("t3_write_cycles", wc, 4);
    @(posedge clock); #1;

    issue(1, 16'hAAAA, 4'h0, 4'h0);
    run_until_done(1, 50, 0, 0, 0, 0, lat, wc);
    check("t4_done_latency", lat, 11);
    check("t4_write_cycles", wc, 4);
    @(posedge clock); #1;

    issue(0, 16'h5678, 4'h0, 4'h0);
    run_until_done(0, 50, 0, 0, 0, 1, lat, wc);
    check("t5_done_latency", lat, 5);
    check("t5_write_cycles", wc, 4);
    start_s[0] = 1'b1;
    value_s[0] = 16'h1111;
    @(posedge clock); #1;
    start_s[0] = 1'b0;
    check("t5_start_in_done_write", wr_s[0], 0);
    check("t5_start_in_done_busy", busy_s[0], 0);
    issue(0, 16'hABCD, 4'b1010, 4'b0000);
    run_until_done(0, 50, 0, 0, 0, 0, lat, wc);
    check("t5_restart_latency", lat, 5);
    @(posedge clock); #1;

    issue(0, 16'h9ABC, 4'h0, 4'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    wreq[0] = 1'b1;
    check("t6_third_write", wr_s[0], 1);
    @(posedge clock); #1;
    reset = 1'b1;
    expq[0].delete();
    @(posedge clock); #1;
    check("t6_rst_write", wr_s[0], 0);
    check("t6_rst_busy", busy_s[0], 0);
    check("t6_rst_done", done_s[0], 0);
    reset   = 1'b0;
    wreq[0] = 1'b0;
    @(posedge clock); #1;
    issue(0, 16'hFEDC, 4'b0110, 4'b1001);
    run_until_done(0, 50, 0, 0, 0, 0, lat, wc);
    check("t6_after_reset_latency", lat, 5);
    @(posedge clock); #1;

    for (int n = 0; n < 12; n++) begin
      int k;
      k = n % 2;
      issue(k, 16'($urandom), 4'($urandom), 4'($urandom));
      run_until_done(k, 400, 0, 0, 1, 0, lat, wc);
      check("rnd_done_seen", lat > 0, 1);
      @(posedge clock); #1;
    end

    check("sb_empty0", expq[0].size(), 0);
    check("sb_empty1", expq[1].size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_chain_writer.md
Name: seven_segment_chain_writer

Overview:
Avalon-MM master that drives a daisy chain of seven-segment display stages. It is the initiator for the chain's slave write port. On a start pulse it latches a NUM_DIGITS hex value and issues one Avalon write per digit, most-significant digit first, honouring waitrequest. Each nibble is encoded into an 8-bit segment pattern {dp,g,f,e,d,c,b,a} on writedata[7:0].

Parameters:
NUM_DIGITS, 8, number of chained display stages and writes per update (1..16).
GAP_CYCLES, 0, idle cycles inserted between accepted writes (0..255).
ACTIVE_LOW, 1, 1 = invert the final 8-bit pattern, including dp.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle request; sampled only in IDLE.
value  in  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i].
dp_mask  in  NUM_DIGITS  bit i lights the decimal point of digit i.
blank_mask  in  NUM_DIGITS  bit i forces segments a..g of digit i off.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse after the last write is accepted.
avm_m0_chipselect  out  1  equal to avm_m0_write.
avm_m0_write  out  1  write request.
avm_m0_byteenable  out  4  4'b0001 while writing, else 4'b0000.
avm_m0_address  out  8  constant 8'd0.
avm_m0_writedata  out  32  {24'd0, pattern}.
avm_m0_waitrequest  in  1  slave stall.

Behaviour:
- Reset, synchronous and active-high: state=IDLE, busy=0, done=0, write=0, chipselect=0, byteenable=0, writedata=0, index=0, gap counter=0. Reset overrides everything, including an in-flight write: write drops at that edge and the chain update is abandoned.
- IDLE:
  - start=1 latches value, dp_mask and blank_mask into shadow registers.
  - Sets index=NUM_DIGITS-1 and enters WRITE. busy=1 from the next cycle.
  - Input changes after latching have no effect on the update in progress.
- WRITE:
  - Drives write=chipselect=1, byteenable=4'b0001 and writedata=encode(index). All are registered outputs, so the first write appears 1 cycle after start.
  - Outputs are held stable while waitrequest=1.
  - A write is accepted at a clock edge where write=1 and waitrequest=0.
  - On acceptance with index==0: go to DONE.
  - On acceptance with index>0: index decrements. If GAP_CYCLES==0, stay in WRITE with the next digit on the following cycle, giving back-to-back writes (one per cycle when waitrequest=0). Otherwise go to GAP with write=0.
- GAP: write=0. Counts GAP_CYCLES cycles, then returns to WRITE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored. start while busy is ignored; there is no queueing.
- Encode:
  - seg7 table, active-high, segments g..a:
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
    - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - blank_mask[i]=1 makes the 7 segment bits 0.
  - bit7 = dp_mask[i], independent of blank.
  - If ACTIVE_LOW, the pattern is bitwise inverted.
- Latency with waitrequest=0 and GAP_CYCLES=0: the first write starts 1 cycle after start, and done pulses NUM_DIGITS+1 cycles after start.
- Index range is 0..NUM_DIGITS-1 and is never wrapped. The gap counter width is 8 bits.

Decomposition:
- Package seven_segment_pkg holds:
  - the state encoding constants (IDLE, WRITE, GAP, DONE);
  - the 16-entry segment table constant;
  - BYTEENABLE_DIGIT=4'b0001 and ADDR_CHAIN=8'd0.
- Sub-module hex_to_seven_segment is purely combinational: nibble, blank, dp and ACTIVE_LOW in; 8-bit pattern out. It is instantiated once on the indexed shadow digit.

Test Plan:
- NUM_DIGITS=4, ACTIVE_LOW=0, GAP=0, waitrequest=0, value=16'h1234, masks=0, start -> writedata[7:0] sequence 06,5B,4F,66 on consecutive cycles 1..4 after start, done at cycle 5, byteenable=0001 on each write.
- Same setup, waitrequest held high 3 cycles on the second write -> write held with 5B stable for 4 cycles, total 4 accepted writes, done delayed by 3 cycles.
- ACTIVE_LOW=1, value=16'h80F0, dp_mask=4'b0001, blank_mask=4'b0100 -> sequence 80 (~7F), FF (blank, dp off), 8E (~71), 40 (~BF: 3F with dp).
- GAP_CYCLES=2, value=16'hAAAA -> writes of 77 separated by exactly 2 idle cycles with write=0, done 11 cycles after start.
- start pulsed again during busy and in the DONE cycle -> ignored, exactly NUM_DIGITS writes. start again from IDLE with a new value -> a new full sequence.
- Reset asserted during the third write with waitrequest=1 -> write, busy and done all 0 at the next edge, state IDLE. A following start produces a complete, correct sequence.
